k2_out_uart_tx: RTL

- Downstream consumer of the K2 core's 8-bit output register R0.
- Watches the R0 value every cycle. Each time the value changes, it queues the new value in a small FIFO.
- Drains the FIFO as 8N1 UART frames (LSB first) on a single serial pin, so program output is observable off-chip without halting the core.
- Same clock domain as the core; no handshake back to the core, which never stalls.

---
 rtl/k2_out_uart_tx.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/k2_out_uart_tx.sv
// k2_out_uart_tx: watches the K2 core's R0 output register, queues every new
// value in a small circular FIFO and drains the queue as LSB-first UART frames
// (start, 8 data bits, stop) on a single pin. The core is never stalled: if the
// queue is full, the new value is dropped and a sticky overflow flag is raised.
// Optional build macro: K2_OUT_UART_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit.
module k2_out_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    r0_in,
  input  logic                          clr_ovf,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef K2_OUT_UART_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t state_reg, state_next;

  logic [7:0]    prev_r0_reg;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;
  logic [BW-1:0] baud_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg, tx_next;
  logic          busy_reg, busy_next;
`ifdef K2_OUT_UART_PARITY_EN
  logic          parity_reg;
`endif

  logic [7:0] head;
  logic       fifo_empty, fifo_full, baud_done;
  logic       push_req, push, drop, pop;

  assign head       = mem[rd_ptr_reg];
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_FULL);
  assign baud_done  = (baud_reg == BAUD_LAST);

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_req = (r0_in != prev_r0_reg);
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic: frames chain straight from STOP into START when more data waits.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (!fifo_empty) state_next = START;
      START: if (baud_done) state_next = DATA;
      DATA:  if (baud_done && bit_reg == 3'd7) begin
`ifdef K2_OUT_UART_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
             end
`ifdef K2_OUT_UART_PARITY_EN
      PARITY: if (baud_done) state_next = STOP;
`endif
      STOP:  if (baud_done) state_next = fifo_empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: FIFO pop strobe and the next registered line/busy levels.
  always_comb begin
    pop       = 1'b0;
    tx_next   = tx_reg;
    busy_next = busy_reg;
    case (state_reg)
      IDLE: if (!fifo_empty) begin
              pop       = 1'b1;
              tx_next   = 1'b0;
              busy_next = 1'b1;
            end
      START: if (baud_done) tx_next = shift_reg[0];
      DATA: if (baud_done) begin
              if (bit_reg == 3'd7) begin
`ifdef K2_OUT_UART_PARITY_EN
                tx_next = parity_reg;
`else
                tx_next = 1'b1;
`endif
              end else begin
                tx_next = shift_reg[1];
              end
            end
`ifdef K2_OUT_UART_PARITY_EN
      PARITY: if (baud_done) tx_next = 1'b1;
`endif
      STOP: if (baud_done) begin
              if (!fifo_empty) begin
                pop     = 1'b1;
                tx_next = 1'b0;
              end else begin
                busy_next = 1'b0;
              end
            end
      default: ;
    endcase
  end

  // Queue storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= r0_in;
  end

  // Change detection, queue bookkeeping, overflow flag and serializer datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r0_reg  <= 8'h00;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      baud_reg     <= '0;
      bit_reg      <= 3'd0;
      shift_reg    <= 8'h00;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
`ifdef K2_OUT_UART_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      // prev_r0 follows the input even when the value itself is dropped.
      prev_r0_reg <= r0_in;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push && !pop)      count_reg <= count_reg + (AW + 1)'(1);
      else if (pop && !push) count_reg <= count_reg - (AW + 1)'(1);
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)         overflow_reg <= 1'b1;
      else if (clr_ovf) overflow_reg <= 1'b0;

      if (state_reg == IDLE || baud_done) baud_reg <= '0;
      else                                baud_reg <= baud_reg + BW'(1);
      if (state_reg == DATA && baud_done) bit_reg <= bit_reg + 3'd1;

      if (pop)                                 shift_reg <= head;
      else if (state_reg == DATA && baud_done) shift_reg <= {1'b0, shift_reg[7:1]};
`ifdef K2_OUT_UART_PARITY_EN
      if (pop) parity_reg <= ^head;
`endif
      tx_reg   <= tx_next;
      busy_reg <= busy_next;
    end
  end

  assign tx         = tx_reg;
  assign busy       = busy_reg;
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;

endmodule
